// File: rtl/config_pkg.sv
// ---------------------------------------------------------------------------
// config_pkg
// Shared FPU configuration: supported format set, field widths, format
// encodings with their bias / fraction width, and the iterative-unit
// scheduler state type and counter width.
// No ports (package).
// ---------------------------------------------------------------------------
package config_pkg;

    // Formats supported: S, D, H, Q
    localparam int FPSIZES  = 4;
    localparam int FMTBITS  = 2;
    // Widest exponent (Q) and log2 of the widest fraction container
    localparam int NE       = 15;
    localparam int LOGFLEN  = 7;

    // Width of the iteration counter
    localparam int SCH_CNTW = LOGFLEN + 1;

    // Format encodings
    localparam logic [FMTBITS-1:0] FMT_S = 2'b00;
    localparam logic [FMTBITS-1:0] FMT_D = 2'b01;
    localparam logic [FMTBITS-1:0] FMT_H = 2'b10;
    localparam logic [FMTBITS-1:0] FMT_Q = 2'b11;

    // Exponent bias per format
    localparam logic [NE-2:0] BIAS_S = 14'd127;
    localparam logic [NE-2:0] BIAS_D = 14'd1023;
    localparam logic [NE-2:0] BIAS_H = 14'd15;
    localparam logic [NE-2:0] BIAS_Q = 14'd16383;

    // Stored fraction width per format
    localparam logic [LOGFLEN-1:0] NF_S = 7'd23;
    localparam logic [LOGFLEN-1:0] NF_D = 7'd52;
    localparam logic [LOGFLEN-1:0] NF_H = 7'd10;
    localparam logic [LOGFLEN-1:0] NF_Q = 7'd112;

    typedef enum logic [1:0] {
        SCH_IDLE,
        SCH_LOAD,
        SCH_ITER,
        SCH_DONE
    } fpsched_state_t;

endpackage

// File: rtl/fmtparams.sv
// ---------------------------------------------------------------------------
// fmtparams
// Decodes a format code into its exponent bias and stored fraction width.
// Formats beyond FPSIZES fall back to single precision.
// Ports:
//   Fmt   in   FMTBITS    format code
//   Bias  out  NE-1       exponent bias
//   Nf    out  LOGFLEN    fraction width
// ---------------------------------------------------------------------------
module fmtparams
    import config_pkg::*;
(
    input  logic [FMTBITS-1:0] Fmt,
    output logic [NE-2:0]      Bias,
    output logic [LOGFLEN-1:0] Nf
);

    always_comb begin
        Bias = BIAS_S;
        Nf   = NF_S;
        case (Fmt)
            FMT_D: begin
                Bias = BIAS_D;
                Nf   = NF_D;
            end
            FMT_H: begin
                if (FPSIZES >= 3) begin
                    Bias = BIAS_H;
                    Nf   = NF_H;
                end
            end
            FMT_Q: begin
                if (FPSIZES >= 4) begin
                    Bias = BIAS_Q;
                    Nf   = NF_Q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
// Combinational round-robin priority rotate. The search starts at the index
// just after Ptr and wraps, so the most recent grantee has lowest priority.
// Ports:
//   Req       in   NREQ           request vector
//   Ptr       in   $clog2(NREQ)   index of the last grant
//   GrantOH   out  NREQ           one-hot grant (all zero when no request)
//   GrantIdx  out  $clog2(NREQ)   binary index of the grant
// ---------------------------------------------------------------------------
module rr_arb #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         Req,
    input  logic [$clog2(NREQ)-1:0] Ptr,
    output logic [NREQ-1:0]         GrantOH,
    output logic [$clog2(NREQ)-1:0] GrantIdx
);

    localparam int IDXW = $clog2(NREQ);

    always_comb begin
        logic        found;
        int unsigned idx;
        GrantOH  = '0;
        GrantIdx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(Ptr) + i) % NREQ;
            if (!found && Req[idx]) begin
                found        = 1'b1;
                GrantOH[idx] = 1'b1;
                GrantIdx     = IDXW'(idx);
            end
        end
    end

endmodule

// File: rtl/fpu_iter_sched.sv
// ---------------------------------------------------------------------------
// fpu_iter_sched
// Round-robin scheduler sharing one iterative FP datapath among NREQ
// requesters. A grant latches the owner and format; the LOAD cycle registers
// the format's Bias/Nf and the iteration count; ITER steps the datapath once
// per cycle; DONE holds the result handshake. A DONE handshake with pending
// requests regrants in the same cycle.
// Optional feature: define FPU_SCHED_PERF_EN to add StallCnt / OpCnt.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   ReqValid/ReqFmt     per-requester request and format
//   ReqReady            one-hot combinational accept
//   Flush               abort current operation
//   StartE/IterE        datapath init pulse / step enable
//   LastIter, IterCnt   final-step flag, remaining steps
//   Bias, Nf            latched format parameters
//   BusyE               not idle
//   DoneValid/DoneId    result handshake with owner index
//   DoneReady           owner accepts the result
//   StallCnt, OpCnt     (FPU_SCHED_PERF_EN) saturating perf counters
// ---------------------------------------------------------------------------
module fpu_iter_sched
    import config_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int RK    = 2,
    parameter int EXTRA = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NREQ-1:0]               ReqValid,
    input  logic [NREQ-1:0][FMTBITS-1:0]  ReqFmt,
    output logic [NREQ-1:0]               ReqReady,
    input  logic                          Flush,
    output logic                          StartE,
    output logic                          IterE,
    output logic                          LastIter,
    output logic [SCH_CNTW-1:0]           IterCnt,
    output logic [NE-2:0]                 Bias,
    output logic [LOGFLEN-1:0]            Nf,
    output logic                          BusyE,
    output logic                          DoneValid,
    output logic [$clog2(NREQ)-1:0]       DoneId,
    input  logic                          DoneReady
`ifdef FPU_SCHED_PERF_EN
   ,output logic [31:0]                   StallCnt,
    output logic [31:0]                   OpCnt
`endif
);

    localparam int IDXW   = $clog2(NREQ);
    localparam int LOG2RK = $clog2(RK);

    fpsched_state_t      state;
    logic [IDXW-1:0]     ptr;
    logic [IDXW-1:0]     owner;
    logic [FMTBITS-1:0]  fmt;

    logic [NREQ-1:0]     grant_oh;
    logic [IDXW-1:0]     grant_idx;
    logic                any_req;
    logic                can_grant;
    logic [NE-2:0]       bias_f;
    logic [LOGFLEN-1:0]  nf_f;
    logic [SCH_CNTW-1:0] load_cnt;

    // Ceiling of (Nf + EXTRA) / RK, computed at counter width.
    function automatic logic [SCH_CNTW-1:0] iter_count(input logic [LOGFLEN-1:0] nf);
        logic [SCH_CNTW-1:0] sum;
        sum = SCH_CNTW'(nf) + SCH_CNTW'(EXTRA + RK - 1);
        return sum >> LOG2RK;
    endfunction

    rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .Req      (ReqValid),
        .Ptr      (ptr),
        .GrantOH  (grant_oh),
        .GrantIdx (grant_idx)
    );

    fmtparams u_fmt (
        .Fmt  (fmt),
        .Bias (bias_f),
        .Nf   (nf_f)
    );

    assign any_req   = |ReqValid;
    // Grants happen only from IDLE or from a completing DONE, never on Flush.
    assign can_grant = !Flush && any_req &&
                       ((state == SCH_IDLE) || ((state == SCH_DONE) && DoneReady));
    assign ReqReady  = can_grant ? grant_oh : '0;
    assign load_cnt  = iter_count(nf_f);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= SCH_IDLE;
            ptr       <= IDXW'(NREQ - 1);
            owner     <= '0;
            fmt       <= '0;
            StartE    <= 1'b0;
            IterE     <= 1'b0;
            LastIter  <= 1'b0;
            IterCnt   <= '0;
            Bias      <= '0;
            Nf        <= '0;
            BusyE     <= 1'b0;
            DoneValid <= 1'b0;
            DoneId    <= '0;
        end else if (Flush) begin
            // Abort: pointer, owner and Bias/Nf keep their values.
            state     <= SCH_IDLE;
            StartE    <= 1'b0;
            IterE     <= 1'b0;
            LastIter  <= 1'b0;
            IterCnt   <= '0;
            BusyE     <= 1'b0;
            DoneValid <= 1'b0;
        end else begin
            case (state)
                SCH_IDLE: begin
                    if (can_grant) begin
                        state  <= SCH_LOAD;
                        owner  <= grant_idx;
                        fmt    <= ReqFmt[grant_idx];
                        ptr    <= grant_idx;
                        StartE <= 1'b1;
                        BusyE  <= 1'b1;
                    end
                end
                SCH_LOAD: begin
                    state    <= SCH_ITER;
                    StartE   <= 1'b0;
                    IterE    <= 1'b1;
                    Bias     <= bias_f;
                    Nf       <= nf_f;
                    IterCnt  <= load_cnt;
                    LastIter <= (load_cnt == SCH_CNTW'(1));
                end
                SCH_ITER: begin
                    if (IterCnt == SCH_CNTW'(1)) begin
                        state     <= SCH_DONE;
                        IterE     <= 1'b0;
                        LastIter  <= 1'b0;
                        IterCnt   <= '0;
                        DoneValid <= 1'b1;
                        DoneId    <= owner;
                    end else begin
                        IterCnt  <= IterCnt - SCH_CNTW'(1);
                        LastIter <= (IterCnt == SCH_CNTW'(2));
                    end
                end
                SCH_DONE: begin
                    if (DoneReady) begin
                        DoneValid <= 1'b0;
                        if (can_grant) begin
                            // Zero-bubble regrant straight into LOAD.
                            state  <= SCH_LOAD;
                            owner  <= grant_idx;
                            fmt    <= ReqFmt[grant_idx];
                            ptr    <= grant_idx;
                            StartE <= 1'b1;
                        end else begin
                            state <= SCH_IDLE;
                            BusyE <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= SCH_IDLE;
                end
            endcase
        end
    end

`ifdef FPU_SCHED_PERF_EN
    // Saturating counters: requests left waiting, and completed handshakes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            StallCnt <= '0;
            OpCnt    <= '0;
        end else begin
            if (any_req && !(|ReqReady) && (StallCnt != '1))
                StallCnt <= StallCnt + 32'd1;
            if (DoneValid && DoneReady && !Flush && (OpCnt != '1))
                OpCnt <= OpCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_iter_sched.sv
// ---------------------------------------------------------------------------
// tb_fpu_iter_sched
// Directed bench for fpu_iter_sched with NREQ=2, RK=2, EXTRA=3, four formats.
// Expected iteration counts: S 13, D 28, H 7, Q 58.
// ---------------------------------------------------------------------------
module tb_fpu_iter_sched;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      ReqValid;
    logic [1:0][1:0] ReqFmt;
    logic [1:0]      ReqReady;
    logic            Flush;
    logic            StartE;
    logic            IterE;
    logic            LastIter;
    logic [7:0]      IterCnt;
    logic [13:0]     Bias;
    logic [6:0]      Nf;
    logic            BusyE;
    logic            DoneValid;
    logic [0:0]      DoneId;
    logic            DoneReady;
`ifdef FPU_SCHED_PERF_EN
    logic [31:0]     StallCnt;
    logic [31:0]     OpCnt;
`endif

    int checks   = 0;
    int failures = 0;

    fpu_iter_sched #(.NREQ(2), .RK(2), .EXTRA(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ReqValid  (ReqValid),
        .ReqFmt    (ReqFmt),
        .ReqReady  (ReqReady),
        .Flush     (Flush),
        .StartE    (StartE),
        .IterE     (IterE),
        .LastIter  (LastIter),
        .IterCnt   (IterCnt),
        .Bias      (Bias),
        .Nf        (Nf),
        .BusyE     (BusyE),
        .DoneValid (DoneValid),
        .DoneId    (DoneId),
        .DoneReady (DoneReady)
`ifdef FPU_SCHED_PERF_EN
       ,.StallCnt  (StallCnt),
        .OpCnt     (OpCnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One complete operation from IDLE back to IDLE with a single requester.
    task automatic do_op(input int idx, input logic [1:0] f, input int expn,
                         input int expbias, input int expnf, input string nm);
        int n;
        ReqValid      = '0;
        ReqValid[idx] = 1'b1;
        ReqFmt[idx]   = f;
        #1;
        chk({nm, "_ready"}, ReqReady, 32'(1 << idx));
        tick();
        ReqValid = '0;
        #1;
        chk({nm, "_load_start"}, StartE, 1);
        chk({nm, "_load_busy"}, BusyE, 1);
        chk({nm, "_load_noready"}, ReqReady, 0);
        tick();
        chk({nm, "_iter_cnt0"}, IterCnt, expn);
        chk({nm, "_bias"}, Bias, expbias);
        chk({nm, "_nf"}, Nf, expnf);
        chk({nm, "_start_low"}, StartE, 0);
        n = 0;
        while (IterE === 1'b1 && n < 200) begin
            n++;
            if (n == expn - 1) chk({nm, "_last_early"}, LastIter, 0);
            if (n == expn)     chk({nm, "_last"}, LastIter, 1);
            tick();
        end
        chk({nm, "_iter_cycles"}, n, expn);
        chk({nm, "_done_valid"}, DoneValid, 1);
        chk({nm, "_done_id"}, DoneId, idx);
        DoneReady = 1'b1;
        tick();
        DoneReady = 1'b0;
        #1;
        chk({nm, "_done_clr"}, DoneValid, 0);
        chk({nm, "_idle"}, BusyE, 0);
        chk({nm, "_bias_hold"}, Bias, expbias);
    endtask

    initial begin
        int w;
        int exp_id[4];
        logic seen_done;
        exp_id    = '{0, 1, 0, 1};
        reset_n   = 1'b0;
        ReqValid  = '0;
        ReqFmt    = '0;
        Flush     = 1'b0;
        DoneReady = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_start", StartE, 0);
        chk("rst_iter", IterE, 0);
        chk("rst_busy", BusyE, 0);
        chk("rst_done", DoneValid, 0);
        chk("rst_cnt", IterCnt, 0);
        chk("rst_bias", Bias, 0);
        chk("rst_nf", Nf, 0);
        reset_n = 1'b1;

        // Single S op on req0, then D/H/Q alternating requesters
        do_op(0, 2'b00, 13, 127, 23, "s_req0");
        do_op(1, 2'b01, 28, 1023, 52, "d_req1");
        do_op(0, 2'b10, 7, 15, 10, "h_req0");
        do_op(1, 2'b11, 58, 16383, 112, "q_req1");

        // Both requesters held valid: 0,1,0,1 with zero-bubble regrant
        ReqValid  = 2'b11;
        ReqFmt    = {2'b10, 2'b10};
        DoneReady = 1'b1;
        #1;
        chk("rr_first_ready", ReqReady, 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (DoneValid !== 1'b1 && w < 50) begin
                tick();
                w++;
            end
            chk("rr_done_wait", DoneValid, 1);
            chk("rr_done_id", DoneId, exp_id[k]);
            if (k < 3) begin
                chk("rr_regrant", ReqReady, 32'(1 << exp_id[k+1]));
                tick();
                chk("rr_no_bubble", StartE, 1);
            end else begin
                ReqValid = '0;
                #1;
                chk("rr_final_noready", ReqReady, 0);
                tick();
                chk("rr_final_idle", BusyE, 0);
            end
        end
        DoneReady = 1'b0;

        // DoneReady withheld in DONE for 5 cycles
        ReqValid = 2'b01;
        ReqFmt[0] = 2'b10;
        tick();
        ReqValid = '0;
        w = 0;
        while (DoneValid !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk("hold_wait", DoneValid, 1);
        ReqValid = 2'b11;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", DoneValid, 1);
            chk("hold_id", DoneId, 0);
            chk("hold_noready", ReqReady, 0);
            tick();
        end
        ReqValid  = '0;
        DoneReady = 1'b1;
        tick();
        DoneReady = 1'b0;
        chk("hold_release", BusyE, 0);

        // Flush in ITER at IterCnt=4 (pointer now 0, so req1 wins)
        ReqValid  = 2'b10;
        ReqFmt[1] = 2'b00;
        #1;
        chk("fl_ready", ReqReady, 2);
        tick();
        ReqValid = '0;
        w = 0;
        while (IterCnt !== 8'd4 && w < 50) begin
            tick();
            w++;
        end
        chk("fl_cnt4", IterCnt, 4);
        chk("fl_in_iter", IterE, 1);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        chk("fl_busy", BusyE, 0);
        chk("fl_iter", IterE, 0);
        chk("fl_start", StartE, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen_done = seen_done | DoneValid;
            tick();
        end
        chk("fl_never_done", seen_done, 0);
        // Flush in IDLE blocks any grant
        Flush    = 1'b1;
        ReqValid = 2'b11;
        #1;
        chk("fl_idle_noready", ReqReady, 0);
        tick();
        Flush = 1'b0;
        #1;
        chk("fl_idle_busy", BusyE, 0);
        chk("fl_rr_next", ReqReady, 1);
        tick();
        ReqValid = '0;
        tick();
        tick();
        tick();
        chk("rs_in_iter", IterE, 1);

        // Reset mid-ITER overrides Flush
        reset_n = 1'b0;
        Flush   = 1'b1;
        tick();
        chk("rs_start", StartE, 0);
        chk("rs_iter", IterE, 0);
        chk("rs_last", LastIter, 0);
        chk("rs_cnt", IterCnt, 0);
        chk("rs_bias", Bias, 0);
        chk("rs_nf", Nf, 0);
        chk("rs_busy", BusyE, 0);
        chk("rs_done", DoneValid, 0);
        chk("rs_doneid", DoneId, 0);
`ifdef FPU_SCHED_PERF_EN
        chk("rs_stallcnt", StallCnt, 0);
        chk("rs_opcnt", OpCnt, 0);
`endif
        reset_n  = 1'b1;
        Flush    = 1'b0;
        ReqValid = 2'b11;
        #1;
        chk("rs_ptr_req0", ReqReady, 1);
        ReqValid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
